// File: rtl/cmp_pkg.sv
// Shared types and flag-to-relation decode for the digit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_rel_t;

  // Relation from subtraction flags; signed uses N^V, unsigned uses the borrow (~C).
  function automatic cmp_rel_t derive_rel(input logic v, input logic n, input logic z,
                                          input logic c, input logic signed_mode);
    cmp_rel_t rel;
    rel.lt = signed_mode ? (n ^ v) : ~c;
    rel.eq = z;
    rel.gt = ~rel.lt & ~z;
    return rel;
  endfunction

endpackage

// File: rtl/digit_sub.sv
// K-bit ripple adder used for one digit of X + ~Y + 1; b arrives already inverted.
module digit_sub #(
  parameter int unsigned K = 8
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [K:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(K); i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[K];
  assign c_msb = c[K-1];

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial comparator: X - Y over N/K cycles, V/N/Z/C flags and LT/EQ/GT via valid/ready.
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned K = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         Signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         V,
  output logic         Nf,
  output logic         Z,
  output logic         C,
  output logic         LT,
  output logic         EQ,
  output logic         GT
);

  localparam int unsigned Digits = N / K;
  localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Digits - 1);

  state_t          state;
  logic [N-1:0]    x_q;
  logic [N-1:0]    y_q;
  logic            sgn_q;
  logic            carry_q;
  logic            zacc_q;
  logic [CntW-1:0] cnt_q;
  cmp_flags_t      flags_q;

  logic [K-1:0] dsum;
  logic         dcout;
  logic         dc_msb;
  logic         zacc_next;
  cmp_rel_t     rel;

  digit_sub #(
    .K(K)
  ) u_digit_sub (
    .a    (x_q[K-1:0]),
    .b    (y_q[K-1:0]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout),
    .c_msb(dc_msb)
  );

  // On the final digit the adder outputs are the MSB digit, so flags come straight from it.
  always_comb begin
    zacc_next = zacc_q & (dsum == '0);
    rel       = derive_rel(dc_msb ^ dcout, dsum[K-1], zacc_next, dcout, sgn_q);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      sgn_q     <= 1'b0;
      carry_q   <= 1'b0;
      zacc_q    <= 1'b0;
      cnt_q     <= '0;
      flags_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q     <= X;
            y_q     <= ~Y;
            sgn_q   <= Signed;
            carry_q <= 1'b1;
            zacc_q  <= 1'b1;
            cnt_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          zacc_q  <= zacc_next;
          carry_q <= dcout;
          x_q     <= x_q >> K;
          y_q     <= y_q >> K;
          if (cnt_q == LastCnt) begin
            flags_q.v  <= dc_msb ^ dcout;
            flags_q.n  <= dsum[K-1];
            flags_q.z  <= zacc_next;
            flags_q.c  <= dcout;
            flags_q.lt <= rel.lt;
            flags_q.eq <= rel.eq;
            flags_q.gt <= rel.gt;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign V  = flags_q.v;
  assign Nf = flags_q.n;
  assign Z  = flags_q.z;
  assign C  = flags_q.c;
  assign LT = flags_q.lt;
  assign EQ = flags_q.eq;
  assign GT = flags_q.gt;

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator: a 32/8 instance and an 8/8 instance on a shared clock/reset.
module tb_seq_comparator;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic        iv_a, ir_a, ov_a, or_a, s_a;
  logic [31:0] x_a, y_a;
  logic        v_a, n_a, z_a, c_a, lt_a, eq_a, gt_a;

  logic        iv_b, ir_b, ov_b, or_b, s_b;
  logic [7:0]  x_b, y_b;
  logic        v_b, n_b, z_b, c_b, lt_b, eq_b, gt_b;

  seq_comparator #(.N(32), .K(8)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .in_valid(iv_a), .in_ready(ir_a), .X(x_a), .Y(y_a),
    .Signed(s_a), .out_valid(ov_a), .out_ready(or_a), .V(v_a), .Nf(n_a), .Z(z_a), .C(c_a),
    .LT(lt_a), .EQ(eq_a), .GT(gt_a)
  );

  seq_comparator #(.N(8), .K(8)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .in_valid(iv_b), .in_ready(ir_b), .X(x_b), .Y(y_b),
    .Signed(s_b), .out_valid(ov_b), .out_ready(or_b), .V(v_b), .Nf(n_b), .Z(z_b), .C(c_b),
    .LT(lt_b), .EQ(eq_b), .GT(gt_b)
  );

  logic       sel;  // 0 = 32-bit instance, 1 = 8-bit instance
  logic       ir, ov;
  logic [6:0] fo;
  assign ir = sel ? ir_b : ir_a;
  assign ov = sel ? ov_b : ov_a;
  assign fo = sel ? {v_b, n_b, z_b, c_b, lt_b, eq_b, gt_b} : {v_a, n_a, z_a, c_a, lt_a, eq_a, gt_a};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [6:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference flags {V,N,Z,C,LT,EQ,GT} for a w-bit X - Y.
  function automatic logic [6:0] model(input logic [31:0] x, input logic [31:0] y,
                                       input logic s, input int w);
    logic [31:0] msb, mask, xm, ym, d;
    logic v, n, z, c, lt, eq, gt;
    msb  = 32'h1 << (w - 1);
    mask = (msb << 1) - 32'h1;
    xm   = x & mask;
    ym   = y & mask;
    d    = (xm - ym) & mask;
    c    = (xm >= ym);
    z    = (d == 0);
    n    = ((d & msb) != 0);
    v    = (((xm ^ ym) & msb) != 0) && (((d ^ xm) & msb) != 0);
    lt   = s ? ((xm ^ msb) < (ym ^ msb)) : (xm < ym);
    eq   = (xm == ym);
    gt   = !lt && !eq;
    return {v, n, z, c, lt, eq, gt};
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic iv, input logic ordy);
    if (sel) begin
      x_b = x[7:0]; y_b = y[7:0]; s_b = s; iv_b = iv; or_b = ordy;
    end else begin
      x_a = x; y_a = y; s_a = s; iv_a = iv; or_a = ordy;
    end
  endtask

  task automatic run_cmp(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int lat, input int hold);
    int         cyc;
    logic [6:0] exp, held;
    logic       stable;
    @(negedge Clock);
    cyc = 0;
    while (!ir && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    check("in_ready_idle", ir, 1);
    drive(x, y, s, 1'b1, 1'b0);
    exp_q.push_back(model(x, y, s, sel ? 8 : 32));
    @(posedge Clock);
    #1 drive(x, y, s, 1'b0, 1'b0);
    cyc = 0;
    while (!ov && cyc < 50) begin
      @(posedge Clock);
      #1 cyc++;
    end
    check("latency", cyc, lat);
    if (!ov) begin
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    check("flags", {25'd0, fo}, {25'd0, exp});
    check("in_ready_done", ir, 0);
    if (hold > 0) begin
      held   = fo;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        drive(~x, y + 32'd1, ~s, (i % 2) == 0, 1'b0);
        @(posedge Clock);
        #1 if (fo !== held || !ov || ir) stable = 1'b0;
      end
      drive(x, y, s, 1'b0, 1'b0);
      check("bp_stable", stable, 1);
    end
    drive(x, y, s, 1'b0, 1'b1);
    @(posedge Clock);
    #1 drive(x, y, s, 1'b0, 1'b0);
    check("out_valid_drop", ov, 0);
    check("in_ready_back", ir, 1);
    check("flags_retained", {25'd0, fo}, {25'd0, exp});
    if (hold > 0) begin
      repeat (6) @(posedge Clock);
      #1 check("no_stray_accept", ov, 0);
    end
  endtask

  initial begin
    logic [31:0] rx, ry;
    sel = 1'b0;
    iv_a = 0; or_a = 0; x_a = 0; y_a = 0; s_a = 0;
    iv_b = 0; or_b = 0; x_b = 0; y_b = 0; s_b = 0;
    Reset = 1'b1;
    #12;
    check("rst_in_ready", ir_a, 1);
    check("rst_out_valid", ov_a, 0);
    check("rst_flags", {v_a, n_a, z_a, c_a, lt_a, eq_a, gt_a}, 0);
    @(negedge Clock) Reset = 1'b0;

    run_cmp(32'd5, 32'd5, 1'b0, 4, 0);
    run_cmp(32'd3, 32'd7, 1'b0, 4, 0);
    run_cmp(32'h8000_0000, 32'd1, 1'b1, 4, 0);
    run_cmp(32'h8000_0000, 32'd1, 1'b0, 4, 0);
    run_cmp(32'h0000_0100, 32'd0, 1'b0, 4, 0);
    run_cmp(32'hFFFF_FFFF, 32'd0, 1'b1, 4, 0);
    run_cmp(32'd0, 32'hFFFF_FFFF, 1'b0, 4, 0);
    run_cmp(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4, 10);
    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = (i == 2) ? rx : $urandom;
      run_cmp(rx, ry, i[0], 4, 0);
    end
    run_cmp(32'h0000_0100, 32'd1, 1'b0, 4, 0);

    // Abort a compare during its second RUN cycle.
    @(negedge Clock);
    drive(32'h1234_5678, 32'h0000_1234, 1'b0, 1'b1, 1'b0);
    @(posedge Clock);
    #1 drive(32'h1234_5678, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    @(posedge Clock);
    #3 Reset = 1'b1;
    #1;
    check("mid_rst_out_valid", ov_a, 0);
    check("mid_rst_flags", {v_a, n_a, z_a, c_a, lt_a, eq_a, gt_a}, 0);
    check("mid_rst_in_ready", ir_a, 1);
    @(negedge Clock) Reset = 1'b0;
    repeat (6) @(posedge Clock);
    #1 check("discarded", ov_a, 0);
    run_cmp(32'd9, 32'd4, 1'b1, 4, 0);

    sel = 1'b1;
    run_cmp(32'h7F, 32'hFF, 1'b1, 1, 0);
    run_cmp(32'h7F, 32'hFF, 1'b0, 1, 0);
    run_cmp(32'h80, 32'h7F, 1'b1, 1, 0);
    run_cmp(32'h42, 32'h42, 1'b1, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
